// File: rtl/logit_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : logit_serializer_if
// Purpose  : Frame-in / element-out bus of the logit serializer. The slave
//            modport is the serializer side, the master modport is the
//            upstream producer plus downstream consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface logit_serializer_if #(
    parameter int NUM_CLASS = 10,
    parameter int DATA_W    = 21,
    parameter int IDX_W     = 4
);
    logic [NUM_CLASS*DATA_W-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        out_en;
    logic signed [DATA_W-1:0]    out_data;
    logic                        out_valid;
    logic                        out_last;
    logic [IDX_W-1:0]            out_idx;

    modport master (
        output in_data, in_valid, out_en,
        input  in_ready, out_data, out_valid, out_last, out_idx
    );

    modport slave (
        input  in_data, in_valid, out_en,
        output in_ready, out_data, out_valid, out_last, out_idx
    );
endinterface
`default_nettype wire

// File: rtl/logit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : logit_serializer
// Purpose  : Accepts a frame of NUM_CLASS parallel signed logits, buffers up
//            to two frames in ping-pong slots and streams each frame one
//            logit per cycle, class 0 first, honouring the downstream enable.
// Revision : 1.0 - initial release
// ============================================================================
module logit_serializer #(
    parameter int NUM_CLASS = 10,
    parameter int DATA_W    = 21,
    parameter int IDX_W     = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    logit_serializer_if.slave  bus,
    output logic               busy
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

    state_t                   state;
    state_t                   state_next;
    logic signed [DATA_W-1:0] slot_mem [2][NUM_CLASS];
    logic [1:0]               count;
    logic [1:0]               count_next;
    logic                     wr_slot;
    logic                     rd_slot;
    logic                     rd_slot_next;
    logic [IDX_W-1:0]         elem_idx;
    logic [IDX_W-1:0]         elem_idx_next;
    logic                     accept;
    logic                     transfer;
    logic                     at_last;

    // Ready depends only on registered occupancy, never on out_en.
    assign bus.in_ready = ~reset & (count != 2'd2);
    assign accept       = bus.in_valid & bus.in_ready;
    assign transfer     = (state == S_STREAM) & bus.out_en;
    assign at_last      = (elem_idx == LAST_IDX);
    assign busy         = (count != 2'd0);

    // Present the current element of the read slot; zeros while idle.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_idx   = '0;
        bus.out_last  = 1'b0;
        if (state == S_STREAM) begin
            bus.out_valid = 1'b1;
            bus.out_data  = slot_mem[rd_slot][elem_idx];
            bus.out_idx   = elem_idx;
            bus.out_last  = at_last;
        end
    end

    // Occupancy bookkeeping and element sequencing; a frame leaves the buffer
    // on its last transfer, so a simultaneous accept keeps the count steady.
    always_comb begin
        state_next    = state;
        elem_idx_next = elem_idx;
        rd_slot_next  = rd_slot;
        count_next    = count;
        case ({accept, transfer & at_last})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next    = S_STREAM;
                    elem_idx_next = '0;
                end
            end
            S_STREAM: begin
                if (transfer) begin
                    if (at_last) begin
                        elem_idx_next = '0;
                        rd_slot_next  = ~rd_slot;
                        // Another frame waiting means element 0 follows with no bubble.
                        if (count_next == 2'd0) begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        elem_idx_next = elem_idx + IDX_W'(1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control state register with synchronous reset; reset drops buffered frames.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= 2'd0;
            wr_slot  <= 1'b0;
            rd_slot  <= 1'b0;
            elem_idx <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            rd_slot  <= rd_slot_next;
            elem_idx <= elem_idx_next;
            if (accept) begin
                wr_slot <= ~wr_slot;
            end
        end
    end

    // Capture a whole frame into the write slot; when streaming with one frame
    // buffered the write slot is always the idle one.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int k = 0; k < NUM_CLASS; k++) begin
                slot_mem[wr_slot][k] <= bus.in_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_logit_serializer
// Purpose  : Scoreboard bench for logit_serializer. Accepted frames are
//            expanded into an expected element queue; a negedge monitor
//            compares handshake state, elements and per-frame argmax.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logit_serializer;

    localparam int NC  = 10;
    localparam int DW  = 21;
    localparam int IW  = 4;
    localparam int LIM = 200;

    typedef struct {
        logic signed [DW-1:0] val;
        int                   idx;
    } elem_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;

    logit_serializer_if #(.NUM_CLASS(NC), .DATA_W(DW), .IDX_W(IW)) bus();

    logit_serializer #(.NUM_CLASS(NC), .DATA_W(DW), .IDX_W(IW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    int    total   = 0;
    int    bad     = 0;
    int    to_req  = 0;
    int    to_seen = 0;
    bit    mon_on  = 1'b0;

    elem_t exp_q[$];
    int    arg_q[$];
    logic signed [DW-1:0] cur_max;
    logic signed [DW-1:0] in_max;
    logic signed [DW-1:0] in_v;
    int    cur_arg;
    int    in_arg;
    int    exp_arg;
    int    frames;
    bit    e_ready;
    bit    e_valid;
    elem_t e;

    int f1[NC] = '{-5, 3, 100, -20000, 7, 0, 99, -1, 42, -100};
    int fa[NC] = '{default: 1};
    int fb[NC] = '{default: -1};
    int fc[NC] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    int fr[NC] = '{-7, 12, -300, 5, 77, 76, -1000, 0, 3, 2};

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: check the outputs against the frame-level model, then advance
    // the model by what the coming edge will do.
    always @(negedge clock) begin
        if (mon_on) begin
            if (to_req != to_seen) begin
                chk("wait_bound", to_seen, to_req);
                to_seen = to_req;
            end
            frames  = (exp_q.size() + NC - 1) / NC;
            e_ready = !reset && (frames < 2);
            e_valid = (exp_q.size() != 0);
            chk("in_ready", bus.in_ready, e_ready);
            chk("out_valid", bus.out_valid, e_valid);
            chk("busy", busy, e_valid);
            if (e_valid) begin
                chk("out_data", $signed(bus.out_data), exp_q[0].val);
                chk("out_idx", bus.out_idx, exp_q[0].idx);
                chk("out_last", bus.out_last, exp_q[0].idx == NC - 1);
            end else begin
                chk("idle_data", $signed(bus.out_data), 0);
                chk("idle_idx", bus.out_idx, 0);
                chk("idle_last", bus.out_last, 0);
            end
            if (reset) begin
                exp_q.delete();
                arg_q.delete();
            end else begin
                if (e_valid && bus.out_en) begin
                    e = exp_q.pop_front();
                    if (e.idx == 0 || $signed(bus.out_data) > cur_max) begin
                        cur_max = $signed(bus.out_data);
                        cur_arg = int'(bus.out_idx);
                    end
                    if (e.idx == NC - 1) begin
                        exp_arg = (arg_q.size() != 0) ? arg_q.pop_front() : -1;
                        chk("argmax", cur_arg, exp_arg);
                    end
                end
                if (bus.in_valid && e_ready) begin
                    for (int k = 0; k < NC; k++) begin
                        in_v = bus.in_data[k*DW +: DW];
                        exp_q.push_back('{val: in_v, idx: k});
                        if (k == 0 || in_v > in_max) begin
                            in_max = in_v;
                            in_arg = k;
                        end
                    end
                    arg_q.push_back(in_arg);
                end
            end
        end
    end

    function automatic logic [NC*DW-1:0] pack(input int v[NC]);
        logic [NC*DW-1:0] r;
        for (int k = 0; k < NC; k++) r[k*DW +: DW] = DW'(v[k]);
        return r;
    endfunction

    function automatic logic [NC*DW-1:0] rnd_frame();
        logic [NC*DW-1:0] r;
        logic [31:0]      x;
        for (int k = 0; k < NC; k++) begin
            x = $urandom;
            case ($urandom_range(0, 5))
                0:       r[k*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
                1:       r[k*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
                default: r[k*DW +: DW] = x[DW-1:0];
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [NC*DW-1:0] fl);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        bus.in_data  = fl;
        bus.in_valid = 1'b1;
        while (!acc && n < LIM) begin
            @(negedge clock);
            acc = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) to_req++;
    endtask

    task automatic wait_idx(input int target);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < LIM) begin
            @(negedge clock);
            hit = bus.out_valid && bus.out_en && (bus.out_idx == IW'(target));
            n++;
        end
        if (!hit) to_req++;
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_en = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while ((busy || bus.out_valid) && n < LIM);
        if (busy || bus.out_valid) to_req++;
        tick();
    endtask

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.out_en   = 1'b0;
        reset        = 1'b1;
        tick();
        mon_on = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Single frame, downstream always enabled.
        bus.out_en = 1'b1;
        offer(pack(f1));
        drain();

        // Stall pattern 1,0,0 repeating.
        fork
            offer(pack(f1));
            begin
                for (int i = 0; i < 40; i++) begin
                    bus.out_en = (i % 3 == 0);
                    tick();
                end
            end
        join
        drain();

        // Back-to-back frames.
        bus.out_en = 1'b1;
        offer(pack(fa));
        offer(pack(fb));
        drain();

        // Buffer full while stalled; third frame held off.
        bus.out_en = 1'b0;
        fork
            begin
                offer(pack(fa));
                offer(pack(fb));
                offer(pack(fc));
            end
            begin
                repeat (30) tick();
                bus.out_en = 1'b1;
            end
        join
        drain();

        // Collision with count=2 on A's last transfer.
        bus.out_en = 1'b0;
        offer(pack(fa));
        offer(pack(fb));
        bus.out_en = 1'b1;
        wait_idx(8);
        offer(pack(fc));
        drain();

        // Accept coinciding with the last transfer while count=1.
        offer(pack(fb));
        wait_idx(8);
        offer(pack(fc));
        drain();

        // Reset while element 4 is presented, then a fresh frame.
        offer(pack(f1));
        wait_idx(3);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        offer(pack(fr));
        drain();

        // Randomised frames and downstream enable.
        fork
            begin
                for (int f = 0; f < 25; f++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    offer(rnd_frame());
                end
            end
            begin
                for (int c = 0; c < 1000; c++) begin
                    bus.out_en = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        drain();

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logit_serializer.md
Name: logit_serializer

Overview:
- Producer-side counterpart of the argmax/softmax stage.
- Takes one frame of NUM_CLASS parallel signed logits from the final fully-connected layer through a valid/ready handshake.
- Buffers up to two frames in ping-pong slots.
- Streams each frame one logit per cycle as data/valid, honouring the downstream enable/stall. Stream order is class 0 first, matching the index the classifier reports.

Parameters:
- NUM_CLASS, 10: logits per frame; the classifier counts exactly 10 per frame.
- DATA_W, 21: signed logit width.
- IDX_W, 4: element index counter width; must satisfy 2^IDX_W >= NUM_CLASS.

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: reset.
- in_data, in, NUM_CLASS*DATA_W: flat logit vector; class k at bits [k*DATA_W +: DATA_W].
- in_valid, in, 1: in_data holds a complete frame.
- in_ready, out, 1: a buffer slot is free.
- out_en, in, 1: downstream enable; element transfers only when out_valid & out_en.
- out_data, out, DATA_W signed: current logit.
- out_valid, out, 1: out_data is valid.
- out_last, out, 1: out_data is element NUM_CLASS-1 of its frame.
- out_idx, out, IDX_W: class index of out_data.
- busy, out, 1: at least one frame is buffered or streaming.

Behaviour:
- Interface: reset is synchronous, active-high; the clock is clock. All state updates on the posedge.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_idx=0, busy=0.
  - Slot count=0, wr_slot=0, rd_slot=0, elem_idx=0.
  - in_ready=0 while reset is high; it is 1 from the first cycle after reset.
- in_ready: ~reset & (count != 2). It depends only on registered state, with no combinational path from out_en.
- Accept: in_valid & in_ready captures all of in_data into slot wr_slot, toggles wr_slot and increments count. in_data is ignored otherwise.
- FSM IDLE / STREAM:
  - IDLE: out_valid=0, out_data=0. On accept, go to STREAM next cycle with elem_idx=0, presenting element 0. Latency is 1 cycle from the accept edge to out_valid.
  - STREAM: out_data = slot[rd_slot][elem_idx], out_idx = elem_idx, out_last = (elem_idx == NUM_CLASS-1).
  - STREAM transfer (out_valid & out_en): elem_idx increments. If out_last, elem_idx clears, rd_slot toggles and count decrements.
  - After the last element: if the other slot is full, stay in STREAM and present element 0 of the next frame in the following cycle, with no bubble. Otherwise go to IDLE and drop out_valid.
- Stall: while out_en=0, out_data, out_idx, out_last and out_valid hold unchanged. There is no timeout.
- Simultaneous accept and last-element transfer in the same cycle: legal when in_ready was 1. Net count is unchanged, the write goes to wr_slot, and the read advances to the other slot.
- Accept while count=1 and streaming: the frame is stored in the idle slot; the streaming slot is never overwritten.
- busy = (count != 0).
- Reset mid-frame: all buffered frames are discarded and out_valid clears next cycle. The next accepted frame streams from element 0. The downstream classifier shares the same reset, so partial frames are not carried over.
- Data is passed bit-exact with no arithmetic; the sign is preserved.

Test Plan:
1. Single frame: after reset, frame logits {-5,3,100,-20000,7,0,99,-1,42,-100} with out_en=1.
   - Expected: out_valid rises 1 cycle after accept.
   - Expected: 10 consecutive cycles with out_idx 0..9 and the values in order.
   - Expected: out_last only with 42's successor -100 at idx 9; then out_valid=0 and busy=0.
2. Stall: same frame, out_en toggled 1,0,0,1,...
   - Expected: the value is held during each low cycle; no element is skipped or duplicated; exactly 10 transfers.
3. Back-to-back: frames A (all 1s) and B (all -1s) offered on consecutive cycles, out_en=1.
   - Expected: in_ready stays 1 for both.
   - Expected: 20 contiguous valid cycles, A idx0-9 then B idx0-9, with no bubble.
4. Full: three frames offered while out_en=0.
   - Expected: the first two are accepted; in_ready=0 after the second, and the third is held off.
   - Expected: when out_en=1, in_ready returns to 1 in the cycle after A's last transfer.
5. Collision: count=2, and a new frame C is offered with in_valid on the cycle of A's last transfer.
   - Expected: C is not accepted that cycle (in_ready was 0); it is accepted the next cycle.
   - Expected: then with count=1, accept coinciding with B's last transfer keeps count=1, and C streams immediately after B.
6. Reset mid-frame: reset asserted at element 4.
   - Expected: out_valid=0 and in_ready=0 during reset.
   - Expected: a fresh frame then streams from idx 0 and the downstream classifier reports its correct argmax.
